// File: rtl/snitch_hwpe_ctrl_arbiter.sv
// Round-robin arbiter sharing one HWPE peripheral control port among the cluster cores.
// One transaction in flight; the response is routed back to its issuer, with a timeout fallback.
module snitch_hwpe_ctrl_arbiter #(
  parameter int unsigned NrCores       = 8,
  parameter int unsigned IdWidth       = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] TimeoutData   = 32'hBADC_AB1E
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrCores-1:0]     core_req_i,
  output logic [NrCores-1:0]     core_gnt_o,
  input  logic [NrCores*32-1:0]  core_add_i,
  input  logic [NrCores-1:0]     core_wen_i,
  input  logic [NrCores*4-1:0]   core_be_i,
  input  logic [NrCores*32-1:0]  core_data_i,
  output logic [31:0]            core_r_data_o,
  output logic [NrCores-1:0]     core_r_valid_o,
  output logic                   periph_req_o,
  input  logic                   periph_gnt_i,
  output logic [31:0]            periph_add_o,
  output logic                   periph_wen_o,
  output logic [3:0]             periph_be_o,
  output logic [31:0]            periph_data_o,
  output logic [IdWidth-1:0]     periph_id_o,
  input  logic [31:0]            periph_r_data_i,
  input  logic                   periph_r_valid_i,
  input  logic [IdWidth-1:0]     periph_r_id_i,
  output logic                   timeout_o,
  output logic                   id_err_o,
  output logic                   stray_rsp_o
);

  localparam int unsigned SelW = $clog2(NrCores);
  localparam int unsigned CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

  typedef enum logic {IDLE, WAIT_RSP} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   rr_q, rr_d;
  logic [SelW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SelW-1:0]   sel;
  logic              found;
  logic              anyReq;
  logic              handshake;
  logic              timeoutHit;

  // Cyclic search for the first requester at or after the round-robin pointer.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NrCores; k++) begin
      int unsigned c;
      c = int'(rr_q) + k;
      if (c >= NrCores) c = c - NrCores;
      if (!found && core_req_i[c]) begin
        sel   = SelW'(c);
        found = 1'b1;
      end
    end
  end

  assign anyReq     = |core_req_i;
  assign handshake  = (state_q == IDLE) && anyReq && periph_gnt_i;
  assign timeoutHit = (TimeoutCycles != 0) && (state_q == WAIT_RSP) && !periph_r_valid_i &&
                      (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = WAIT_RSP;
          idx_d   = sel;
          rr_d    = (sel == SelW'(NrCores - 1)) ? '0 : sel + SelW'(1);
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        if (cnt_q != CntW'(TimeoutCycles)) cnt_d = cnt_q + CntW'(1);
        if (periph_r_valid_i || timeoutHit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even mid-transaction.
  always_comb begin
    core_gnt_o     = '0;
    core_r_valid_o = '0;
    core_r_data_o  = '0;
    periph_req_o   = 1'b0;
    periph_add_o   = '0;
    periph_wen_o   = 1'b0;
    periph_be_o    = '0;
    periph_data_o  = '0;
    periph_id_o    = '0;
    timeout_o      = 1'b0;
    id_err_o       = 1'b0;
    stray_rsp_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          periph_req_o = anyReq;
          stray_rsp_o  = periph_r_valid_i;
          if (anyReq) begin
            periph_add_o    = core_add_i[sel*32 +: 32];
            periph_wen_o    = core_wen_i[sel];
            periph_be_o     = core_be_i[sel*4 +: 4];
            periph_data_o   = core_data_i[sel*32 +: 32];
            periph_id_o     = IdWidth'(sel);
            core_gnt_o[sel] = periph_gnt_i;
          end
        end
        WAIT_RSP: begin
          if (periph_r_valid_i) begin
            core_r_valid_o[idx_q] = 1'b1;
            core_r_data_o         = periph_r_data_i;
            id_err_o              = (periph_r_id_i != IdWidth'(idx_q));
          end else if (timeoutHit) begin
            core_r_valid_o[idx_q] = 1'b1;
            core_r_data_o         = TimeoutData;
            timeout_o             = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snitch_hwpe_ctrl_arbiter.sv
// Self-checking bench for snitch_hwpe_ctrl_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_snitch_hwpe_ctrl_arbiter;

  localparam int N   = 8;
  localparam int IdW = 8;
  localparam int TO  = 4;
  localparam logic [31:0] TOD = 32'hBADCAB1E;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     coreReq;
  logic [N-1:0]     coreGnt;
  logic [N*32-1:0]  coreAdd;
  logic [N-1:0]     coreWen;
  logic [N*4-1:0]   coreBe;
  logic [N*32-1:0]  coreData;
  logic [31:0]      coreRData;
  logic [N-1:0]     coreRValid;
  logic             periphReq;
  logic             periphGnt;
  logic [31:0]      periphAdd;
  logic             periphWen;
  logic [3:0]       periphBe;
  logic [31:0]      periphData;
  logic [IdW-1:0]   periphId;
  logic [31:0]      periphRData;
  logic             periphRValid;
  logic [IdW-1:0]   periphRId;
  logic             timeoutPulse;
  logic             idErr;
  logic             strayRsp;

  always #5 clock = ~clock;

  snitch_hwpe_ctrl_arbiter #(
    .NrCores(N), .IdWidth(IdW), .TimeoutCycles(TO), .TimeoutData(TOD)
  ) dut (
    .clk_i(clock), .rst_i(reset),
    .core_req_i(coreReq), .core_gnt_o(coreGnt), .core_add_i(coreAdd), .core_wen_i(coreWen),
    .core_be_i(coreBe), .core_data_i(coreData), .core_r_data_o(coreRData),
    .core_r_valid_o(coreRValid), .periph_req_o(periphReq), .periph_gnt_i(periphGnt),
    .periph_add_o(periphAdd), .periph_wen_o(periphWen), .periph_be_o(periphBe),
    .periph_data_o(periphData), .periph_id_o(periphId), .periph_r_data_i(periphRData),
    .periph_r_valid_i(periphRValid), .periph_r_id_i(periphRId), .timeout_o(timeoutPulse),
    .id_err_o(idErr), .stray_rsp_o(strayRsp)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, how long it has waited, and who is next in line.
  bit mBusy;
  int mOwner, mWait, mPtr;
  int lastGrant;
  int grantLog[$];

  logic [N-1:0] snapGnt, snapRv;
  logic [31:0]  snapData;
  logic [IdW-1:0] snapId;
  logic snapTo, snapIdErr, snapStray;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mBusy = 0; mOwner = 0; mWait = 0; mPtr = 0;
  endfunction

  function automatic int pickCore();
    for (int k = 0; k < N; k++)
      if (coreReq[(mPtr + k) % N]) return (mPtr + k) % N;
    return -1;
  endfunction

  task automatic setCore(input int c, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
    coreAdd[c*32 +: 32] = a;
    coreWen[c]          = w;
    coreBe[c*4 +: 4]    = b;
    coreData[c*32 +: 32] = d;
  endtask

  task automatic randomCore(input int c);
    setCore(c, $urandom, 1'($urandom), 4'($urandom), $urandom);
  endtask

  // One clock cycle: compare outputs with the model, then advance the model and the clock.
  task automatic runCycle();
    int sel;
    logic [N-1:0] eGnt, eRv;
    logic [31:0] eData;
    logic eTo, eIdErr, eStray, eReq;
    logic [36:0] eFields;
    logic [39:0] eFields2;
    #1;
    eGnt = '0; eRv = '0; eData = '0; eTo = 0; eIdErr = 0; eStray = 0; eReq = 0;
    eFields = '0; eFields2 = '0;
    sel = pickCore();
    lastGrant = -1;
    if (!mBusy) begin
      eStray = periphRValid;
      if (sel >= 0) begin
        eReq     = 1;
        eFields  = {coreAdd[sel*32 +: 32], coreBe[sel*4 +: 4], coreWen[sel]};
        eFields2 = {coreData[sel*32 +: 32], IdW'(sel)};
        if (periphGnt) begin
          eGnt      = N'(1) << sel;
          lastGrant = sel;
        end
      end
      checkOutput("periph_fields", {periphAdd, periphBe, periphWen}, eFields);
      checkOutput("periph_data_id", {periphData, periphId}, eFields2);
    end else if (periphRValid) begin
      eRv    = N'(1) << mOwner;
      eData  = periphRData;
      eIdErr = (periphRId != IdW'(mOwner));
    end else if (TO != 0 && mWait == TO - 1) begin
      eRv   = N'(1) << mOwner;
      eData = TOD;
      eTo   = 1;
    end
    checkOutput("periph_req", periphReq, eReq);
    checkOutput("core_gnt", coreGnt, eGnt);
    checkOutput("core_r_valid", coreRValid, eRv);
    checkOutput("core_r_data", coreRData, eData);
    checkOutput("flags_to_iderr_stray", {timeoutPulse, idErr, strayRsp}, {eTo, eIdErr, eStray});
    snapGnt = coreGnt; snapRv = coreRValid; snapData = coreRData; snapId = periphId;
    snapTo = timeoutPulse; snapIdErr = idErr; snapStray = strayRsp;
    for (int i = 0; i < N; i++)
      if (coreGnt[i]) begin
        grantLog.push_back(i);
        break;
      end
    if (!mBusy) begin
      if (lastGrant >= 0) begin
        mBusy = 1; mOwner = lastGrant; mPtr = (lastGrant + 1) % N; mWait = 0;
      end
    end else if (eRv != '0) begin
      mBusy = 0;
    end else begin
      mWait++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic [IdW-1:0] rid);
    periphGnt = g; periphRValid = rv; periphRData = rd; periphRId = rid;
    runCycle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt_rv"}, {coreGnt, coreRValid}, '0);
    checkOutput({tag, "_rdata"}, coreRData, '0);
    checkOutput({tag, "_periph"}, {periphReq, periphAdd, periphWen, periphBe}, '0);
    checkOutput({tag, "_pdata"}, {periphData, periphId}, '0);
    checkOutput({tag, "_flags"}, {timeoutPulse, idErr, strayRsp}, '0);
  endtask

  task automatic resetDut();
    reset = 1; coreReq = '0; periphGnt = 0; periphRValid = 0; periphRData = '0; periphRId = '0;
    #2;
    checkAllZero("reset");
    @(posedge clock);
    #1;
    reset = 0;
    modelReset();
  endtask

  initial begin
    coreAdd = '0; coreWen = '0; coreBe = '0; coreData = '0;
    resetDut();

    // Single read from core 3.
    setCore(3, 32'h100, 1'b1, 4'hF, 32'h0);
    coreReq = 8'h08;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("single_gnt", snapGnt, 8'h08);
    checkOutput("single_id", snapId, 3);
    coreReq = '0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h1234, 3);
    checkOutput("single_rvalid", snapRv, 8'h08);
    checkOutput("single_rdata", snapData, 32'h1234);

    // Fairness: everybody requests continuously, one-cycle responses.
    resetDut();
    for (int c = 0; c < N; c++) randomCore(c);
    coreReq = 8'hFF;
    grantLog.delete();
    for (int r = 0; r < 9; r++) begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, $urandom, IdW'(mOwner));
    end
    checkOutput("fair_count", grantLog.size(), 9);
    for (int r = 0; r < 9 && r < grantLog.size(); r++)
      checkOutput($sformatf("fair_order_%0d", r), grantLog[r], r % N);

    // Wrap-around: move the pointer to 6, then cores 1 and 7 compete.
    coreReq = 8'h20;
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_pre_gnt", snapGnt, 8'h20);
    coreReq = 8'h00;
    applyStimulus(0, 1, 32'h5, 5);
    coreReq = 8'h82;
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_first", snapGnt, 8'h80);
    coreReq = 8'h02;
    applyStimulus(0, 1, 32'h7, 7);
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_second", snapGnt, 8'h02);
    coreReq = 8'h00;
    applyStimulus(0, 1, 32'h1, 1);

    // Timeout on the 4th waiting cycle, then a late response counted as stray.
    coreReq = 8'h10;
    applyStimulus(1, 0, 0, 0);
    coreReq = 8'h00;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("to_early", {snapTo, snapRv}, '0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("to_pulse", snapTo, 1);
    checkOutput("to_rvalid", snapRv, 8'h10);
    checkOutput("to_rdata", snapData, 32'hBADCAB1E);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h55, 4);
    checkOutput("late_stray", snapStray, 1);
    checkOutput("late_rvalid", snapRv, 8'h00);

    // Real response on the timeout cycle wins.
    coreReq = 8'h01;
    applyStimulus(1, 0, 0, 0);
    coreReq = 8'h00;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'hCAFEF00D, 0);
    checkOutput("tie_to", snapTo, 0);
    checkOutput("tie_rvalid", snapRv, 8'h01);
    checkOutput("tie_rdata", snapData, 32'hCAFEF00D);

    // Response id mismatch still goes to the owner.
    coreReq = 8'h04;
    applyStimulus(1, 0, 0, 0);
    coreReq = 8'h00;
    applyStimulus(0, 1, 32'h2222, 5);
    checkOutput("iderr_pulse", snapIdErr, 1);
    checkOutput("iderr_rvalid", snapRv, 8'h04);

    // Reset while waiting: outputs drop at once, the late response is stray.
    coreReq = 8'h40;
    applyStimulus(1, 0, 0, 0);
    coreReq = 8'h00;
    applyStimulus(0, 0, 0, 0);
    periphRValid = 1; periphRData = 32'h77; periphRId = 6;
    reset = 1;
    #1;
    checkAllZero("midreset");
    @(posedge clock);
    #1;
    reset = 0;
    modelReset();
    applyStimulus(0, 1, 32'h77, 6);
    checkOutput("post_reset_stray", snapStray, 1);
    checkOutput("post_reset_rvalid", snapRv, 8'h00);

    // Randomized traffic with stray responses, wrong ids and timeouts.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [IdW-1:0] rid;
      for (int c = 0; c < N; c++)
        if (!coreReq[c] && !(mBusy && mOwner == c) && $urandom_range(0, 3) == 0) begin
          randomCore(c);
          coreReq[c] = 1'b1;
        end
      rid = ($urandom_range(0, 7) == 0) ? IdW'($urandom_range(0, 7)) : IdW'(mOwner);
      applyStimulus(1'($urandom_range(0, 1)),
                    mBusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0),
                    $urandom, rid);
      if (lastGrant >= 0) coreReq[lastGrant] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
